// File: rtl/spi_master.sv
// SPI master (mode 0, MSB first) for the 6502 bus at $e110..$e113, clocked on the falling edge of phi2.
// Optional interrupt output and CONTROL.IRQE bit are enabled by defining SPI_IRQ_EN.
module spi_master #(
   parameter int SS_COUNT = 2
) (
   input  logic                phi2,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                rwb,
   input  logic [1:0]          address,
   input  logic [7:0]          data_in,
   output logic [7:0]          data_out,
   output logic                sclk,
   output logic                mosi,
   input  logic                miso,
   output logic [SS_COUNT-1:0] ss_n
`ifdef SPI_IRQ_EN
   ,
   output logic                irq_n
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} state_t;

   state_t              state_q, state_d;
   logic [7:0]          tx_sr_q, tx_sr_d;
   logic [7:0]          rx_sr_q, rx_sr_d;
   logic [7:0]          data_q, data_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [3:0]          div_cnt_q, div_cnt_d;
   logic [3:0]          div_lat_q, div_lat_d;
   logic [3:0]          div_q, div_d;
   logic                irqe_q, irqe_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic                done_q, done_d;
   logic                wcol_q, wcol_d;
   logic [SS_COUNT-1:0] select_q, select_d;

   logic       wr_data, wr_ctrl, wr_sel, rd_data, rd_status;
   logic       busy, start, done_set;
   logic [7:0] sel_rd;

   assign wr_data   = enable & ~rwb & (address == 2'd0);
   assign wr_ctrl   = enable & ~rwb & (address == 2'd2);
   assign wr_sel    = enable & ~rwb & (address == 2'd3);
   assign rd_data   = enable &  rwb & (address == 2'd0);
   assign rd_status = enable &  rwb & (address == 2'd1);
   assign busy      = (state_q != ST_IDLE);

   always_comb begin
      state_d   = state_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      data_d    = data_q;
      bit_cnt_d = bit_cnt_q;
      div_cnt_d = div_cnt_q;
      div_lat_d = div_lat_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      start     = 1'b0;
      done_set  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wr_data) begin
               start     = 1'b1;
               tx_sr_d   = data_in;
               mosi_d    = data_in[7];
               bit_cnt_d = 3'd0;
               div_lat_d = div_q;
               div_cnt_d = div_q;
               state_d   = ST_LOW;
            end
         end
         ST_LOW: begin
            if (div_cnt_q != 4'd0) begin
               div_cnt_d = div_cnt_q - 4'd1;
            end else begin
               sclk_d    = 1'b1;
               rx_sr_d   = {rx_sr_q[6:0], miso};
               div_cnt_d = div_lat_q;
               state_d   = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (div_cnt_q != 4'd0) begin
               div_cnt_d = div_cnt_q - 4'd1;
            end else begin
               sclk_d    = 1'b0;
               div_cnt_d = div_lat_q;
               if (bit_cnt_q == 3'd7) begin
                  data_d   = rx_sr_q;
                  done_set = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_sr_d   = {tx_sr_q[6:0], 1'b0};
                  mosi_d    = tx_sr_q[6];
                  state_d   = ST_LOW;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Completion beats a same-edge DATA read; a write during any busy edge flags a collision.
   always_comb begin
      done_d = done_q;
      if (done_set)
         done_d = 1'b1;
      else if (rd_data || start)
         done_d = 1'b0;

      wcol_d = wcol_q;
      if (wr_data && busy)
         wcol_d = 1'b1;
      else if (rd_status)
         wcol_d = 1'b0;

      div_d    = div_q;
      irqe_d   = irqe_q;
      select_d = select_q;
      if (wr_ctrl) begin
         div_d = data_in[3:0];
`ifdef SPI_IRQ_EN
         irqe_d = data_in[7];
`else
         irqe_d = 1'b0;
`endif
      end
      if (wr_sel)
         select_d = data_in[SS_COUNT-1:0];
   end

   always_ff @(negedge phi2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         tx_sr_q   <= 8'h00;
         rx_sr_q   <= 8'h00;
         data_q    <= 8'h00;
         bit_cnt_q <= 3'd0;
         div_cnt_q <= 4'd0;
         div_lat_q <= 4'd0;
         div_q     <= 4'hF;
         irqe_q    <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         done_q    <= 1'b0;
         wcol_q    <= 1'b0;
         select_q  <= '0;
      end else begin
         state_q   <= state_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         data_q    <= data_d;
         bit_cnt_q <= bit_cnt_d;
         div_cnt_q <= div_cnt_d;
         div_lat_q <= div_lat_d;
         div_q     <= div_d;
         irqe_q    <= irqe_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         done_q    <= done_d;
         wcol_q    <= wcol_d;
         select_q  <= select_d;
      end
   end

   always_comb begin
      sel_rd = 8'h00;
      sel_rd[SS_COUNT-1:0] = select_q;
   end

   always_comb begin
      data_out = 8'h00;
      if (enable && rwb) begin
         case (address)
            2'd0:    data_out = data_q;
            2'd1:    data_out = {busy, done_q, wcol_q, 5'b00000};
            2'd2:    data_out = {irqe_q, 3'b000, div_q};
            default: data_out = sel_rd;
         endcase
      end
   end

   assign sclk = sclk_q;
   assign mosi = mosi_q;

   for (genvar gi = 0; gi < SS_COUNT; gi++) begin : g_ss
      assign ss_n[gi] = ~select_q[gi];
   end

`ifdef SPI_IRQ_EN
   assign irq_n = ~(irqe_q & done_q);
`endif

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: expected mosi bits and received bytes are queued at stimulus time.
module tb_spi_master;
   localparam int SS = 2;

   logic          phi2 = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic          rwb = 1'b1;
   logic [1:0]    address = 2'd0;
   logic [7:0]    data_in = 8'h00;
   logic [7:0]    data_out;
   logic          sclk, mosi;
   wire           miso;
   logic [SS-1:0] ss_n;
`ifdef SPI_IRQ_EN
   logic          irq_n;
`endif

   logic loop_en = 1'b0;
   logic miso_fix = 1'b0;
   assign miso = loop_en ? mosi : miso_fix;

   int n_checks = 0;
   int n_fail = 0;
   bit       exp_bit_q[$];
   bit [7:0] exp_rx_q[$];

   spi_master #(.SS_COUNT(SS)) dut (
      .phi2(phi2), .reset_n(reset_n), .enable(enable), .rwb(rwb),
      .address(address), .data_in(data_in), .data_out(data_out),
      .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
`ifdef SPI_IRQ_EN
      , .irq_n(irq_n)
`endif
   );

   always #5 phi2 = ~phi2;

   task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
      @(posedge phi2); #1;
      enable = 1'b1; rwb = 1'b0; address = a; data_in = d;
      @(negedge phi2); #1;
      enable = 1'b0; rwb = 1'b1;
   endtask

   task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
      @(posedge phi2); #1;
      enable = 1'b1; rwb = 1'b1; address = a;
      #2 d = data_out;
      @(negedge phi2); #1;
      enable = 1'b0;
   endtask

   // act: 0 none, 1 DATA write 0x11, 2 DATA read, 3 SELECT write 0x02, 4 CONTROL write 0x00 (all at edge act_k)
   task automatic run_transfer(input logic [3:0] div, input logic [7:0] tx, input logic loop,
                               input logic [7:0] rx_exp, input int act, input int act_k);
      int half, total, falls, edges, last_edge, done_k;
      logic prev_s, prev_m, b;
      logic [7:0] st, rd, exp_st, exp_rx;
      half = int'(div) + 1;
      total = 16 * half;
      falls = 0; edges = 0; last_edge = 0; done_k = 0;
      loop_en = loop;
      for (int i = 7; i >= 0; i--) exp_bit_q.push_back(tx[i]);
      exp_rx_q.push_back(rx_exp);
      cpu_write(2'd0, tx);
      prev_s = sclk; prev_m = mosi;
      n_checks++;
      if (mosi !== tx[7] || sclk !== 1'b0) begin
         n_fail++;
         $display("FAIL start_mosi tx=%h mosi=%b sclk=%b required mosi=%b sclk=0", tx, mosi, sclk, tx[7]);
      end
      for (int k = 1; k <= total + 8 && done_k == 0; k++) begin
         @(posedge phi2); #1;
         enable = 1'b1;
         if (k == act_k && act == 1) begin rwb = 1'b0; address = 2'd0; data_in = 8'h11; end
         else if (k == act_k && act == 2) begin rwb = 1'b1; address = 2'd0; end
         else if (k == act_k && act == 3) begin rwb = 1'b0; address = 2'd3; data_in = 8'h02; end
         else if (k == act_k && act == 4) begin rwb = 1'b0; address = 2'd2; data_in = 8'h00; end
         else if (act == 1 && k > act_k) begin rwb = 1'b1; address = 2'd3; end
         else begin rwb = 1'b1; address = 2'd1; end
         #2 st = data_out;
         if (rwb && address == 2'd1) begin
            n_checks++;
            if (st[7] !== 1'b1) begin
               n_fail++;
               $display("FAIL busy tx=%h cycle=%0d status=%h required BUSY=1", tx, k, st);
            end
         end
         @(negedge phi2); #1;
         enable = 1'b0; rwb = 1'b1;
         if (k == act_k && act == 3) begin
            n_checks++;
            if (ss_n !== 2'b01) begin
               n_fail++;
               $display("FAIL select_mid ss_n=%b required 01", ss_n);
            end
         end
         if (mosi !== prev_m) begin
            n_checks++;
            if (!(prev_s && !sclk)) begin
               n_fail++;
               $display("FAIL mosi_edge tx=%h cycle=%0d mosi changed with sclk %b->%b required falling", tx, k, prev_s, sclk);
            end
         end
         if (sclk !== prev_s) begin
            n_checks++;
            if ((edges == 0 && k != half) || (edges != 0 && k - last_edge != half)) begin
               n_fail++;
               $display("FAIL half_period tx=%h cycle=%0d last=%0d required spacing %0d", tx, k, last_edge, half);
            end
            edges++; last_edge = k;
            if (sclk) begin
               n_checks++;
               if (exp_bit_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL mosi_bit tx=%h extra sclk rise at cycle %0d required none", tx, k);
               end else begin
                  b = exp_bit_q.pop_front();
                  if (mosi !== b) begin
                     n_fail++;
                     $display("FAIL mosi_bit tx=%h cycle=%0d mosi=%b required %b", tx, k, mosi, b);
                  end
               end
            end else begin
               falls++;
               if (falls == 8) done_k = k;
            end
         end
         prev_s = sclk; prev_m = mosi;
      end
      n_checks++;
      if (done_k != total) begin
         n_fail++;
         $display("FAIL xfer_len tx=%h done at cycle %0d required %0d", tx, done_k, total);
      end
      exp_bit_q.delete();
      exp_st = {1'b0, 1'b1, (act == 1), 5'b00000};
      cpu_read(2'd1, st);
      n_checks++;
      if (st !== exp_st) begin
         n_fail++;
         $display("FAIL status_done tx=%h status=%h required %h", tx, st, exp_st);
      end
      cpu_read(2'd0, rd);
      exp_rx = exp_rx_q.pop_front();
      n_checks++;
      if (rd !== exp_rx) begin
         n_fail++;
         $display("FAIL rx_data tx=%h data=%h required %h", tx, rd, exp_rx);
      end
      cpu_read(2'd1, st);
      n_checks++;
      if (st !== 8'h00) begin
         n_fail++;
         $display("FAIL status_clear tx=%h status=%h required 00", tx, st);
      end
      $display("xfer tx=%h div=%0d act=%0d@%0d rx=%h cycles=%0d", tx, div, act, act_k, rd, done_k);
   endtask

   task automatic test_reset();
      logic [7:0] r;
      logic [7:0] exp_regs [4];
      exp_regs[0] = 8'h00; exp_regs[1] = 8'h00; exp_regs[2] = 8'h0F; exp_regs[3] = 8'h00;
      repeat (3) @(posedge phi2);
      #1;
      n_checks++;
      if (sclk !== 1'b0 || mosi !== 1'b0 || ss_n !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_pins sclk=%b mosi=%b ss_n=%b required 0 0 11", sclk, mosi, ss_n);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cpu_read(2'(i), r);
         n_checks++;
         if (r !== exp_regs[i]) begin
            n_fail++;
            $display("FAIL reset_reg%0d value=%h required %h", i, r, exp_regs[i]);
         end
      end
      $display("reset regs checked");
   endtask

   task automatic test_loopback();
      logic [7:0] r;
      cpu_write(2'd2, 8'h00);
      cpu_write(2'd3, 8'h01);
      n_checks++;
      if (ss_n !== 2'b10) begin
         n_fail++;
         $display("FAIL select_ss ss_n=%b required 10", ss_n);
      end
      cpu_read(2'd2, r);
      n_checks++;
      if (r !== 8'h00) begin
         n_fail++;
         $display("FAIL control_rd value=%h required 00", r);
      end
      run_transfer(4'd0, 8'hA5, 1'b1, 8'hA5, 0, 0);
   endtask

   task automatic test_div3();
      miso_fix = 1'b1;
      cpu_write(2'd2, 8'h03);
      run_transfer(4'd3, 8'h3C, 1'b0, 8'hFF, 4, 10);
      miso_fix = 1'b0;
   endtask

   task automatic test_collision();
      cpu_write(2'd2, 8'h00);
      run_transfer(4'd0, 8'h22, 1'b1, 8'h22, 1, 5);
      run_transfer(4'd0, 8'h81, 1'b1, 8'h81, 1, 16);
   endtask

   task automatic test_done_race();
      run_transfer(4'd0, 8'h5A, 1'b1, 8'h5A, 2, 16);
   endtask

   task automatic test_select_mid();
      logic [7:0] r;
      run_transfer(4'd0, 8'hC3, 1'b1, 8'hC3, 3, 7);
      cpu_read(2'd3, r);
      n_checks++;
      if (r !== 8'h02) begin
         n_fail++;
         $display("FAIL select_rd value=%h required 02", r);
      end
   endtask

   task automatic test_reset_mid();
      int falls;
      logic prev_s;
      logic [7:0] r;
      cpu_write(2'd2, 8'h01);
      cpu_write(2'd3, 8'h03);
      loop_en = 1'b1;
      cpu_write(2'd0, 8'hF0);
      falls = 0; prev_s = sclk;
      for (int k = 0; k < 100 && !(falls == 4 && sclk); k++) begin
         @(negedge phi2); #1;
         if (prev_s && !sclk) falls++;
         prev_s = sclk;
      end
      @(posedge phi2); #1;
      enable = 1'b1; rwb = 1'b1; address = 2'd1;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (sclk !== 1'b0 || mosi !== 1'b0 || ss_n !== 2'b11 || data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid sclk=%b mosi=%b ss_n=%b status=%h required 0 0 11 00", sclk, mosi, ss_n, data_out);
      end
      enable = 1'b0;
      @(posedge phi2); #1;
      reset_n = 1'b1;
      cpu_read(2'd2, r);
      n_checks++;
      if (r !== 8'h0F) begin
         n_fail++;
         $display("FAIL reset_mid_ctrl value=%h required 0F", r);
      end
      $display("reset mid-transfer after %0d falls", falls);
      cpu_write(2'd2, 8'h00);
      cpu_write(2'd3, 8'h01);
      run_transfer(4'd0, 8'h69, 1'b1, 8'h69, 0, 0);
   endtask

`ifdef SPI_IRQ_EN
   task automatic test_irq();
      logic [7:0] r;
      loop_en = 1'b1;
      cpu_write(2'd2, 8'h80);
      cpu_write(2'd0, 8'h55);
      repeat (15) @(negedge phi2);
      #1;
      n_checks++;
      if (irq_n !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_early irq_n=%b required 1", irq_n);
      end
      @(negedge phi2); #1;
      n_checks++;
      if (irq_n !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_done irq_n=%b required 0", irq_n);
      end
      cpu_read(2'd0, r);
      n_checks++;
      if (irq_n !== 1'b1 || r !== 8'h55) begin
         n_fail++;
         $display("FAIL irq_clear irq_n=%b data=%h required 1 55", irq_n, r);
      end
      $display("irq transfer data=%h", r);
   endtask
`endif

   initial begin
      test_reset();
      test_loopback();
      test_div3();
      test_collision();
      test_done_race();
      test_select_mid();
      test_reset_mid();
`ifdef SPI_IRQ_EN
      test_irq();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master.md
# spi_master

Memory-mapped SPI master bus device for the 6502 system, decoded at $e110..$e113 and selected by the SPI enable line from the address decoder. The CPU writes a byte to start an 8-bit mode-0 transfer and reads the received byte back. The block generates SCLK from PHI2 through a programmable divider and drives two active-low slave selects for SD card and peripherals.

## Interface
Parameters:
- SS_COUNT, 2, number of slave-select outputs (1..8)

Ports:
- phi2  in  1  system clock; one clock, all state on falling edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  device select from address decoder (SPI line)
- rwb  in  1  6502 R/W: 1 = read, 0 = write
- address  in  2  register select, A1..A0
- data_in  in  8  CPU write data
- data_out  out  8  CPU read data
- sclk  out  1  SPI clock
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- ss_n  out  SS_COUNT  slave selects, active low
- irq_n  out  1  interrupt request, active low (only with SPI_IRQ_EN)

## Operation
Registers:
- 0 DATA: W starts a transfer if idle. R returns the last received byte and clears DONE.
- 1 STATUS: R only. bit7 BUSY, bit6 DONE, bit5 WCOL, bits 4..0 read 0. A read clears WCOL. Writes are ignored.
- 2 CONTROL: R/W. bits 3..0 DIV, bit7 IRQE (only with macro, else reads 0). Other bits read 0.
- 3 SELECT: R/W, bits SS_COUNT-1..0. ss_n = ~SELECT. Unused bits read 0.

Access rules:
- Register effects occur only when enable=1.
- data_out = selected register when enable & rwb, else 0x00. It is combinational.

Shift engine: mode 0 (CPOL=0, CPHA=0), MSB first. Signals are tx_sr, rx_sr, bit_cnt (3 bit), div_cnt (4 bit), and div_lat.
- IDLE: sclk=0, BUSY=0. On a DATA write: tx_sr=data_in, mosi=data_in[7], bit_cnt=0, div_lat=DIV, div_cnt=DIV, BUSY=1, DONE=0, then go to LOW.
- LOW: sclk=0. If div_cnt≠0, decrement. Otherwise set sclk=1, rx_sr={rx_sr[6:0],miso}, div_cnt=div_lat, then go to HIGH.
- HIGH: sclk=1. If div_cnt≠0, decrement. Otherwise set sclk=0 and div_cnt=div_lat.
  - If bit_cnt=7: DATA read register=rx_sr, DONE=1, BUSY=0, then go to IDLE.
  - Else: bit_cnt++, shift tx_sr left, mosi=new tx_sr[7], then go to LOW.

Boundary conditions:
- DATA write while BUSY, including the completion edge: data is ignored and WCOL=1 (sticky).
- DONE set and a DATA read on the same edge: set wins, and DONE=1.
- A CONTROL write mid-transfer does not affect the current transfer, because div_lat is held.
- SELECT writes take effect immediately, including mid-transfer.
- Reset mid-transfer aborts it. All outputs go to their reset values at once.
- mosi holds the last bit after a transfer.

Reset values:
- sclk=0, mosi=0, ss_n=all 1, data_out=0x00.
- DATA=0x00, STATUS=0x00, CONTROL DIV=0xF with IRQE=0, SELECT=0.
- irq_n=1.

## Timing
- Every register write, read side effect, and engine step happens on the falling edge of phi2. Write data is stable at the end of PHI2-high.
- data_out is valid within phi2-high while enable and rwb hold.
- Each SCLK half period is DIV+1 phi2 cycles.
- A transfer takes 16·(DIV+1) cycles from the write edge to the edge that sets DONE.
- The first rising sclk edge comes DIV+1 cycles after the start edge.
- miso is sampled at the sclk rising transition edge.
- mosi changes only on sclk falling transitions, or at start.
- BUSY reads 1 on the first read cycle after the start write.

## Configuration
- SPI_IRQ_EN defined:
  - irq_n port exists, with irq_n = ~(IRQE & DONE), registered-state derived.
  - CONTROL bit7 is R/W.
- SPI_IRQ_EN undefined:
  - irq_n port is absent.
  - CONTROL bit7 ignores writes and reads 0.

## Test plan
- Reset released, then read all four registers. Expect DATA=0x00, STATUS=0x00, CONTROL=0x0F, SELECT=0x00, ss_n=all 1, and sclk=0.
- DIV=0, SELECT=0x01, write DATA=0xA5 with miso looped to mosi. Expect:
  - 8 sclk pulses, 2 cycles each; mosi sequence 1,0,1,0,0,1,0,1.
  - DONE after 16 cycles; DATA reads 0xA5; a second STATUS read gives DONE=0.
- DIV=3, write 0x3C with miso tied 1. Expect BUSY for 64 cycles, sclk half period of 4 cycles, and DATA=0xFF.
- Write DATA=0x11 during a transfer of 0x22. Expect 0x22 shifted out, WCOL=1, then WCOL=0 after a STATUS read.
- Assert reset_n=0 at bit 4 of a transfer. Expect sclk=0, ss_n=all 1, and STATUS=0x00 immediately. A new transfer after release works.
- With SPI_IRQ_EN defined, IRQE=1, transfer 0x55. Expect irq_n low at DONE and high after the DATA read.
